// File: rtl/if_id_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register: default bubble
// instruction, register-field positions and the next-state selector.
package if_id_reg_pkg;

    // sll $0,$0,0 -- the canonical MIPS no-op used for bubbles
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Source register fields of an R/I-type instruction word
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam int REG_ADDR_W  = 5;
    localparam int EXC_CAUSE_W = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // How the pipeline register is updated when not in reset
    typedef enum logic [1:0] {
        UPD_LOAD  = 2'd0,
        UPD_HOLD  = 2'd1,
        UPD_FLUSH = 2'd2
    } upd_sel_e;

    function automatic reg_addr_t field_rs(input logic [31:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic reg_addr_t field_rt(input logic [31:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// Bundle of fetch-side inputs, hazard inputs and IF/ID outputs.
// master: the fetch/hazard side driving the register; slave: the register.
interface if_id_reg_if #(
    parameter int PC_WIDTH  = 6,
    parameter int CNT_WIDTH = 8
) ();
    logic [PC_WIDTH-1:0]                   PCnext_in;
    logic [31:0]                           Instruction_in;
    logic                                  Branch;
    logic                                  Zero;
    logic [if_id_reg_pkg::EXC_CAUSE_W-1:0] ExceptionCause;
    logic                                  ExtStall;
    logic                                  IDEX_MemRead;
    if_id_reg_pkg::reg_addr_t              IDEX_Rt;

    logic                                  PCWrite;
    logic [PC_WIDTH-1:0]                   PCnext_out;
    logic [31:0]                           Instruction_out;
    logic                                  Valid_out;
    if_id_reg_pkg::reg_addr_t              Rs;
    if_id_reg_pkg::reg_addr_t              Rt;
    logic                                  Bubble;
    logic [CNT_WIDTH-1:0]                  StallCount;

    modport master (
        output PCnext_in, Instruction_in, Branch, Zero, ExceptionCause,
               ExtStall, IDEX_MemRead, IDEX_Rt,
        input  PCWrite, PCnext_out, Instruction_out, Valid_out, Rs, Rt,
               Bubble, StallCount
    );

    modport slave (
        input  PCnext_in, Instruction_in, Branch, Zero, ExceptionCause,
               ExtStall, IDEX_MemRead, IDEX_Rt,
        output PCWrite, PCnext_out, Instruction_out, Valid_out, Rs, Rt,
               Bubble, StallCount
    );
endinterface

// File: rtl/if_id_reg_hazard_unit.sv
// Load-use hazard detection for the IF/ID stage. Only present when
// IFID_HAZARD_DETECT_EN is defined.
`ifdef IFID_HAZARD_DETECT_EN
module if_id_reg_hazard_unit
    import if_id_reg_pkg::*;
(
    input  logic      mem_read_i,
    input  reg_addr_t idex_rt_i,
    input  logic      valid_i,
    input  reg_addr_t rs_i,
    input  reg_addr_t rt_i,
    input  logic      ext_stall_i,
    input  logic      flush_i,
    output logic      load_use_o,
    output logic      stall_o,
    output logic      bubble_o,
    output logic      pc_write_o
);

    // Stall when the load in ID/EX writes a register the ID instruction reads;
    // $0 and bubbles never hazard, and a redirect always frees the PC.
    always_comb begin
        load_use_o = mem_read_i && valid_i && (idex_rt_i != '0) &&
                     ((idex_rt_i == rs_i) || (idex_rt_i == rt_i));
        stall_o    = load_use_o || ext_stall_i;
        pc_write_o = !stall_o || flush_i;
        bubble_o   = load_use_o && !flush_i;
    end

endmodule
`endif

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction and PC+4, holds on
// stall, inserts a NOP bubble on branch/exception redirect.
// Optional feature macro: IFID_HAZARD_DETECT_EN (load-use detection and
// stall performance counter); without it only ExtStall can stall.
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter int          PC_WIDTH  = 6,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int          CNT_WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    if_id_reg_if.slave bus
);

    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                valid_q, valid_d;
    logic                flush;
    logic                stall;
    logic                bubble;
    logic                pc_write;
    reg_addr_t           rs_s;
    reg_addr_t           rt_s;
    upd_sel_e            upd_sel;

    // Register-field views of the held instruction
    always_comb begin
        rs_s = field_rs(instr_q);
        rt_s = field_rt(instr_q);
    end

    // Redirect: taken branch or any nonzero exception cause
    always_comb begin
        flush = (bus.Branch && bus.Zero) || (bus.ExceptionCause != '0);
    end

`ifdef IFID_HAZARD_DETECT_EN
    logic                 load_use;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    if_id_reg_hazard_unit u_hazard (
        .mem_read_i  (bus.IDEX_MemRead),
        .idex_rt_i   (bus.IDEX_Rt),
        .valid_i     (valid_q),
        .rs_i        (rs_s),
        .rt_i        (rt_s),
        .ext_stall_i (bus.ExtStall),
        .flush_i     (flush),
        .load_use_o  (load_use),
        .stall_o     (stall),
        .bubble_o    (bubble),
        .pc_write_o  (pc_write)
    );

    // Saturating count of load-use stall cycles (counts even under flush)
    always_comb begin
        cnt_d = cnt_q;
        if (load_use && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.StallCount = cnt_q;
`else
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{bus.IDEX_MemRead, bus.IDEX_Rt};

    // Without hazard detection only an external freeze can stall
    always_comb begin
        stall    = bus.ExtStall;
        pc_write = !stall || flush;
        bubble   = 1'b0;
    end

    assign bus.StallCount = '0;
`endif

    // Update priority below reset: flush, then stall, then load
    always_comb begin
        upd_sel = UPD_LOAD;
        if (flush) begin
            upd_sel = UPD_FLUSH;
        end else if (stall) begin
            upd_sel = UPD_HOLD;
        end
    end

    // Next-state of the pipeline register
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        case (upd_sel)
            UPD_FLUSH: begin
                instr_d = NOP_INSTR;
                pc_d    = '0;
                valid_d = 1'b0;
            end
            UPD_HOLD: begin
                instr_d = instr_q;
                pc_d    = pc_q;
                valid_d = valid_q;
            end
            default: begin
                instr_d = bus.Instruction_in;
                pc_d    = bus.PCnext_in;
                valid_d = 1'b1;
            end
        endcase
    end

    // Pipeline register with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Instruction_out = instr_q;
    assign bus.PCnext_out      = pc_q;
    assign bus.Valid_out       = valid_q;
    assign bus.Rs              = rs_s;
    assign bus.Rt              = rt_s;
    assign bus.PCWrite         = pc_write;
    assign bus.Bubble          = bubble;

endmodule

// File: doc/if_id_reg.md
# if_id_reg

IF/ID pipeline register with load-use hazard detection for the MIPS pipeline. Sits directly downstream of the instruction-fetch stage: captures the fetched instruction and its PC+4 each cycle, holds them during stalls, and replaces them with a NOP bubble on taken branches or exceptions. Drives `PCWrite` back to fetch and `Bubble` forward to ID/EX control.

## Interface
- `PC_WIDTH`, 6, width of PC values.
- `NOP_INSTR`, 32'h0000_0000, instruction word inserted on flush/reset (`sll $0,$0,0`).
- `CNT_WIDTH`, 8, width of the stall performance counter.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `PCnext_in`  in  PC_WIDTH  PC+4 from fetch.
- `Instruction_in`  in  32  fetched instruction.
- `Branch`, `Zero`  in  1 each  taken-branch redirect when both high.
- `ExceptionCause`  in  3  nonzero = exception redirect.
- `ExtStall`  in  1  external freeze request (e.g. memory wait).
- `IDEX_MemRead`  in  1  instruction in ID/EX is a load.
- `IDEX_Rt`  in  5  destination register of that load.
- `PCWrite`  out  1  fetch PC enable.
- `PCnext_out`  out  PC_WIDTH  registered PC+4.
- `Instruction_out`  out  32  registered instruction.
- `Valid_out`  out  1  registered instruction is real (not a bubble).
- `Rs`, `Rt`  out  5 each  `Instruction_out[25:21]`, `[20:16]`.
- `Bubble`  out  1  ID must zero control signals into ID/EX this cycle.
- `StallCount`  out  CNT_WIDTH  saturating count of load-use stall cycles.

## Operation
- `flush` = (`Branch` && `Zero`) || (`ExceptionCause` != 0).
- `load_use` = `IDEX_MemRead` && `Valid_out` && `IDEX_Rt` != 0 && (`IDEX_Rt` == `Rs` || `IDEX_Rt` == `Rt`).
- `stall` = `load_use` || `ExtStall`.
- Register update priority per rising edge: `rst` > `flush` > `stall` > load.
  - rst: `Instruction_out`=NOP_INSTR, `PCnext_out`=0, `Valid_out`=0, `StallCount`=0.
  - flush: `Instruction_out`=NOP_INSTR, `PCnext_out`=0, `Valid_out`=0.
  - stall: all three hold.
  - load: capture `Instruction_in`, `PCnext_in`; `Valid_out`=1.
- `PCWrite` = !`stall` || `flush` (a redirect is never blocked by a stall).
- `Bubble` = `load_use` && !`flush`.
- `StallCount` increments by 1 on each edge where `load_use` is high and `rst` is low; saturates at all-ones, no wrap.
- Outputs `Rs`/`Rt` are pure slices of the register; `PCWrite`/`Bubble` are combinational from register state and inputs.

## Timing
- Latency: 1 cycle from `Instruction_in` to `Instruction_out`.
- Load-use: exactly one stall cycle per hazard; next cycle ID/EX holds the bubble, so `load_use` drops and the held instruction proceeds.
- `ExtStall` held N cycles -> register held N cycles, `PCWrite` low N cycles.
- Flush with simultaneous stall: flush wins, `PCWrite`=1, `Bubble`=0, NOP loaded.
- Reset mid-stall: NOP/invalid next cycle; `StallCount` cleared; `PCWrite` after reset = 1 (Valid_out=0 kills load_use).
- Rt=$0 or bubble in IF/ID never raises a hazard.

## Configuration
- `IFID_HAZARD_DETECT_EN` defined: load-use detection as above.
- Not defined: `load_use` tied 0; `stall` = `ExtStall` only; `Bubble`=0; `StallCount` held at 0 (register removed).

## Structure
- Shared package: `NOP_INSTR` constant, register-field slice positions (RS_MSB/LSB, RT_MSB/LSB), exception-cause width.
- One sub-module natural: `hazard_unit` (combinational `load_use`/`Bubble`/`PCWrite`), instantiated only under the macro.

## Test plan
- Reset: assert `rst` 1 cycle -> `Instruction_out`=0, `Valid_out`=0, `PCnext_out`=0, `PCWrite`=1, `StallCount`=0.
- Streaming: feed 0x8C01_0004 / PC 4, then 0x0002_1820 / PC 8 -> outputs follow 1 cycle later, `Valid_out`=1.
- Load-use: IF/ID=`add $3,$1,$2` (0x0022_1820), `IDEX_MemRead`=1, `IDEX_Rt`=1 -> `PCWrite`=0, `Bubble`=1, register held, `StallCount`=1; clear MemRead next cycle -> resumes.
- Flush vs stall: `Branch`=`Zero`=1 during load-use -> next cycle NOP, `Valid_out`=0, `PCWrite`=1 during that cycle.
- Exception: `ExceptionCause`=3'b010 -> NOP loaded, `Valid_out`=0.
- Saturation: force 300 consecutive load-use cycles with CNT_WIDTH=8 -> `StallCount`=255, no wrap; rebuild without `IFID_HAZARD_DETECT_EN` -> `PCWrite` stays 1, count 0.
